// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8-bit UART receiver with optional parity, one stop bit and framing/parity error strobes
module uart_rx_deserializer #(
  parameter int CLK_PER_BIT       = 5208,
  parameter int CLK_COUNTER_WIDTH = $clog2(CLK_PER_BIT),
  parameter int PARITY_EN         = 0,
  parameter int PARITY_ODD        = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  localparam logic [CLK_COUNTER_WIDTH-1:0] LAST  = CLK_COUNTER_WIDTH'(CLK_PER_BIT - 1);
  localparam logic [CLK_COUNTER_WIDTH-1:0] HLAST = CLK_COUNTER_WIDTH'(CLK_PER_BIT / 2 - 1);
  state_t state, state_n;
  logic [CLK_COUNTER_WIDTH-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift_reg, shift_n, p_data_n;
  logic [1:0] sync;
  logic par_bit, par_n, dv_n, pe_n, fe_n, rx_s, tick, half;
  assign rx_s = sync[1];
  assign busy = state != IDLE;
  assign tick = cnt == LAST;
  assign half = cnt == HLAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync        <= 2'b11;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      p_data      <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync        <= {sync[0], rx_in};
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift_reg   <= shift_n;
      par_bit     <= par_n;
      p_data      <= p_data_n;
      data_valid  <= dv_n;
      parity_err  <= pe_n;
      framing_err <= fe_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CLK_COUNTER_WIDTH'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    par_n     = par_bit;
    p_data_n  = p_data;
    dv_n      = 1'b0;
    pe_n      = 1'b0;
    fe_n      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (half) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n            = '0;
        shift_n[bit_idx] = rx_s;
        bit_idx_n        = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        cnt_n   = '0;
        par_n   = rx_s;
        state_n = STOP;
      end
      STOP: if (tick) begin
        cnt_n = '0;
        if (rx_s) begin
          p_data_n = shift_reg;
          dv_n     = 1'b1;
          pe_n     = (PARITY_EN != 0) && (^shift_reg ^ par_bit ^ (PARITY_ODD != 0));
          state_n  = IDLE;
        end else begin
          fe_n    = 1'b1;
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive side of the UART link: samples the asynchronous serial line, detects the start bit, recovers 8 data bits (LSB first), an optional parity bit and one stop bit, and presents the byte on a parallel bus with a one-cycle valid strobe. It pairs with the TX serializer at the other end of the link and uses the same bit-time parameterisation (50 MHz clk, 9600 baud). Output feeds the RX byte consumer (FIFO or register file) directly; no backpressure.

## Interface
- CLK_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600); must be ≥ 4.
- CLK_COUNTER_WIDTH, $clog2(CLK_PER_BIT), bit-time counter width.
- PARITY_EN, 0, 1 = frame carries a parity bit between data and stop.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line, idle high, asynchronous to clk.
- p_data  out  8  last received byte; holds until the next good frame.
- data_valid  out  1  one-cycle pulse: p_data updated with a new byte.
- parity_err  out  1  one-cycle pulse, coincident with data_valid, when parity mismatches.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high in every state except IDLE.

## Operation
- rx_in passes through a 2-flop synchronizer (both reset to 1); rx_s = second flop. All decisions use rx_s only.
- HALF = CLK_PER_BIT/2 (integer division). Bit counter bit_idx 0..7; bit-time counter cnt.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: cnt=0. rx_s==0 → START.
- START: cnt counts up; at cnt==HALF-1, sample rx_s, cnt←0. rx_s==1 → false start, IDLE (no outputs). rx_s==0 → DATA, bit_idx←0.
- DATA: at cnt==CLK_PER_BIT-1, cnt←0 and shift_reg[bit_idx]←rx_s. bit_idx==7 → PARITY if PARITY_EN else STOP; otherwise bit_idx+1.
- PARITY: at cnt==CLK_PER_BIT-1, cnt←0, capture rx_s as par_bit → STOP.
- STOP: at cnt==CLK_PER_BIT-1, sample rx_s.
  - rx_s==1: p_data←shift_reg, data_valid←1, parity_err←(PARITY_EN && (^shift_reg ^ par_bit ^ PARITY_ODD)), → IDLE.
  - rx_s==0: framing_err←1, p_data unchanged, data_valid stays 0, → WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE (prevents a break/low line from being read as endless frames).
- Parity error does not suppress data_valid; consumer decides.
- data_valid, parity_err, framing_err are registered and self-clear the next cycle.

## Timing
- Reset values: p_data=8'h00, data_valid=0, parity_err=0, framing_err=0, busy=0; FSM=IDLE, cnt=0, bit_idx=0, synchronizer=2'b11.
- Reset asserted mid-frame: all state returns to reset values immediately; no strobe is emitted for the aborted frame.
- T0 = posedge at which IDLE sees rx_s==0 (2 clk after the line falls). Start sample edge S0 = T0 + HALF.
- Data bit k sampled at S0 + (k+1)·CLK_PER_BIT; parity at S0 + 9·CLK_PER_BIT; stop at S0 + (9+PARITY_EN)·CLK_PER_BIT.
- data_valid / framing_err high for exactly the one cycle after the stop-sample edge.
- Back-to-back frames: after a good stop, FSM is in IDLE half a bit before the stop bit ends; a start bit immediately following is detected without loss.
- Glitch low shorter than HALF-1 cycles (after sync) is rejected as false start.
- busy rises the cycle after T0, falls the cycle data_valid rises (good frame) or when WAIT_HIGH exits.

## Test plan
- Use CLK_PER_BIT=16 in sim. Send 0xA5 (PARITY_EN=0), line idle high → one data_valid pulse, p_data=8'hA5, no error pulses, timing per S0 formula.
- Low glitch of 4 clk on idle line → FSM returns to IDLE, no strobes, p_data unchanged.
- Frame 0x3C with stop bit held low, then line high → framing_err one pulse, data_valid 0, p_data keeps prior value, busy until line high.
- PARITY_EN=1 even: send 0x07 with parity 1 → data_valid, parity_err=0; same byte with parity 0 → data_valid and parity_err=1 same cycle.
- Back-to-back 0x55, 0xAA, 0xFF with no idle gap → three data_valid pulses, p_data 8'h55, 8'hAA, 8'hFF in order.
- Assert rst during bit 4 of 0x81, release, send 0x42 → no strobe for aborted frame, then p_data=8'h42 with single data_valid.
